multiport_packer3: RTL

//  Gathers a serial stream of partial sums into PORTS-wide groups and presents each

---
 rtl/multiport_packer3.sv | 109 ++++++++++
 1 files changed

// File: rtl/multiport_packer3.sv
// multiport_packer3
// Collects a serial ready/valid stream of signed partial sums into groups of
// PORTS words and presents each group in parallel, lane k holding the k-th
// word of the group. A flush request emits a partially filled group with the
// unwritten lanes zeroed. The output slot holds its group until downstream
// takes it, while gathering of the next group continues behind it.
module multiport_packer3 #(
    parameter int WIDTH = 19,
    parameter int PORTS = 3
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_iv,
    input  logic [WIDTH-1:0]                  in_id,
    output logic                              in_ir,
    input  logic                              flush_i,
    output logic                              port_ov,
    output logic [PORTS-1:0][WIDTH-1:0]       port_od,
    output logic [$clog2(PORTS+1)-1:0]        port_nv,
    input  logic                              port_ir
);

    localparam int IDXW = $clog2(PORTS);
    localparam int NVW  = $clog2(PORTS+1);

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_e;

    slot_e                       slot_q, slot_d;
    logic [IDXW-1:0]             idx_q, idx_d;
    logic [PORTS-1:0][WIDTH-1:0] collect_q, collect_d;
    logic [PORTS-1:0][WIDTH-1:0] od_q, od_d;
    logic [NVW-1:0]              nv_q, nv_d;

    logic                        slotFree;
    logic                        lastLane;
    logic                        accept;
    logic                        groupFull;
    logic                        flushFire;
    logic [PORTS-1:0][WIDTH-1:0] merged;

    // Handshake decode: the last lane may only be filled when the output slot can take the group.
    always_comb begin
        slotFree  = (slot_q == SLOT_EMPTY) || port_ir;
        lastLane  = (idx_q == IDXW'(PORTS-1));
        in_ir     = !lastLane || slotFree;
        accept    = in_iv && in_ir;
        groupFull = accept && lastLane;
        flushFire = flush_i && slotFree && ((idx_q != '0) || accept);
    end

    // Collected lanes with this cycle's accepted word dropped into its lane.
    always_comb begin
        merged = collect_q;
        for (int k = 0; k < PORTS; k++) begin
            if (accept && (idx_q == IDXW'(k))) begin
                merged[k] = in_id;
            end
        end
    end

    // Next-state: emit a full or flushed group, otherwise gather and drain the slot.
    always_comb begin
        slot_d    = slot_q;
        idx_d     = idx_q;
        collect_d = collect_q;
        od_d      = od_q;
        nv_d      = nv_q;
        if (groupFull || flushFire) begin
            od_d      = merged;
            nv_d      = groupFull ? NVW'(PORTS) : (NVW'(idx_q) + NVW'(accept));
            slot_d    = SLOT_FULL;
            collect_d = '0;
            idx_d     = '0;
        end else begin
            if (accept) begin
                collect_d = merged;
                idx_d     = idx_q + IDXW'(1);
            end
            if ((slot_q == SLOT_FULL) && port_ir) begin
                slot_d = SLOT_EMPTY;
            end
        end
    end

    // State registers; reset discards any partial or pending group.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q    <= SLOT_EMPTY;
            idx_q     <= '0;
            collect_q <= '0;
            od_q      <= '0;
            nv_q      <= '0;
        end else begin
            slot_q    <= slot_d;
            idx_q     <= idx_d;
            collect_q <= collect_d;
            od_q      <= od_d;
            nv_q      <= nv_d;
        end
    end

    assign port_ov = (slot_q == SLOT_FULL);
    assign port_od = od_q;
    assign port_nv = nv_q;

endmodule
